// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache controller.
// Holds the address-field layout, line geometry, FSM state encoding and
// small helpers that slice fetch addresses and refill lines.
package icache_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int BANKS    = 8;
  localparam int TAG_W    = 19;
  localparam int WORD_W   = 3;
  localparam int OFFSET_W = 5;
  localparam int SETS     = 1 << INDEX_W;
  localparam int LINE_W   = BANKS * DATA_W;

  localparam int WORD_LSB = 2;
  localparam int IDX_LSB  = 5;
  localparam int TAG_LSB  = 13;

  // One-hot controller states.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LOOKUP = 4'b0010,
    ST_ASKMEM = 4'b0100,
    ST_REFILL = 4'b1000
  } state_e;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[IDX_LSB +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[WORD_LSB +: WORD_W];
  endfunction

  // Bank b of a line sits at bits [32b+31:32b].
  function automatic logic [DATA_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] w);
    return line[DATA_W*int'(w) +: DATA_W];
  endfunction

endpackage

// File: rtl/icache_if.sv
// Bus bundles around the instruction cache controller.
//   icache_cpu_if : fetch unit <-> cache (request/ready, returned word, flush)
//   icache_ram_if : cache -> data-bank and tag RAMs (sync read, sync write)
//   icache_mem_if : cache -> memory bus line-fill channel
// In every bundle the modport "master" is the side that issues requests.
interface icache_cpu_if;
  import icache_pkg::*;

  logic              cpu_req_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              cpu_rdata_valid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cache_flush;

  modport master (
    output cpu_req_valid, cpu_addr, cache_flush,
    input  cpu_ready, cpu_rdata_valid, cpu_rdata
  );

  modport slave (
    input  cpu_req_valid, cpu_addr, cache_flush,
    output cpu_ready, cpu_rdata_valid, cpu_rdata
  );
endinterface

interface icache_ram_if;
  import icache_pkg::*;

  logic               ram_rd_en;
  logic [INDEX_W-1:0] ram_rd_addr;
  logic [LINE_W-1:0]  bank_rdata;
  logic [TAG_W-1:0]   tag_rdata;
  logic               ram_wr_en;
  logic [INDEX_W-1:0] ram_wr_addr;
  logic [LINE_W-1:0]  ram_wr_data;
  logic [TAG_W-1:0]   tag_wr_data;

  modport master (
    output ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data, tag_wr_data,
    input  bank_rdata, tag_rdata
  );

  modport slave (
    input  ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data, tag_wr_data,
    output bank_rdata, tag_rdata
  );
endinterface

interface icache_mem_if;
  import icache_pkg::*;

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req_ready;
  logic              mem_rdata_valid;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr,
    input  mem_req_ready, mem_rdata_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr,
    output mem_req_ready, mem_rdata_valid, mem_rdata
  );
endinterface

// File: rtl/icache_valid_array.sv
// Per-set valid bits kept in flops so reset and flush clear all sets at once.
// Ports:
//   clk, rst_n   clock, async active-low clear
//   flush_i      synchronous clear of every set
//   set_i        mark set_idx_i valid
//   rd_idx_i     combinational read index -> rd_valid_o
module icache_valid_array
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               set_i,
  input  logic [INDEX_W-1:0] set_idx_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o
);

  logic [SETS-1:0] valid_q;

  // Flush and set never coincide (flush only in IDLE, set only in REFILL);
  // flush still takes priority so a clear can never be partially undone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (set_i) begin
      valid_q[set_idx_i] <= 1'b1;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 256 sets x 32-byte lines.
// Sequences the bank/tag RAMs between the fetch unit and the memory bus.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   cpu           fetch request/response and flush (slave side)
//   ram           bank + tag RAM read/write ports (master side)
//   mem           line-fill request/response (master side)
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | ready for a fetch; RAM read issued on accept; flush here
// ST_LOOKUP | RAM data valid, compare tag and valid bit
// ST_ASKMEM | line-fill request held until the bus accepts it
// ST_REFILL | waiting for the fill line; write RAMs and return word
module icache_ctrl
  import icache_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  icache_cpu_if.slave   cpu,
  icache_ram_if.master  ram,
  icache_mem_if.master  mem
);

  state_e             state_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [WORD_W-1:0]  word_q;
  logic               cpu_rdata_valid_q;
  logic [DATA_W-1:0]  cpu_rdata_q;
  logic               mem_req_valid_q;
  logic [ADDR_W-1:0]  mem_addr_q;

  logic cpu_ready;
  logic accept;
  logic flush_req;
  logic refill_we;
  logic valid_rd;
  logic hit;

  // Gating with reset_n keeps every output low while reset is held,
  // even though state_q already sits in IDLE.
  assign cpu_ready = reset_n & (state_q == ST_IDLE) & ~cpu.cache_flush;
  assign flush_req = reset_n & (state_q == ST_IDLE) &  cpu.cache_flush;
  assign accept    = cpu_ready & cpu.cpu_req_valid;
  assign refill_we = (state_q == ST_REFILL) & mem.mem_rdata_valid;
  assign hit       = valid_rd & (ram.tag_rdata == tag_q);

  icache_valid_array u_valid (
    .clk        (clk),
    .rst_n      (reset_n),
    .flush_i    (flush_req),
    .set_i      (refill_we),
    .set_idx_i  (idx_q),
    .rd_idx_i   (idx_q),
    .rd_valid_o (valid_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= ST_IDLE;
      tag_q             <= '0;
      idx_q             <= '0;
      word_q            <= '0;
      cpu_rdata_valid_q <= 1'b0;
      cpu_rdata_q       <= '0;
      mem_req_valid_q   <= 1'b0;
      mem_addr_q        <= '0;
    end else begin
      cpu_rdata_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tag_q   <= addr_tag(cpu.cpu_addr);
            idx_q   <= addr_index(cpu.cpu_addr);
            word_q  <= addr_word(cpu.cpu_addr);
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            cpu_rdata_q       <= line_word(ram.bank_rdata, word_q);
            cpu_rdata_valid_q <= 1'b1;
            state_q           <= ST_IDLE;
          end else begin
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= {tag_q, idx_q, {OFFSET_W{1'b0}}};
            state_q         <= ST_ASKMEM;
          end
        end
        ST_ASKMEM: begin
          if (mem.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (mem.mem_rdata_valid) begin
            cpu_rdata_q       <= line_word(mem.mem_rdata, word_q);
            cpu_rdata_valid_q <= 1'b1;
            state_q           <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu.cpu_ready       = cpu_ready;
  assign cpu.cpu_rdata_valid = cpu_rdata_valid_q;
  assign cpu.cpu_rdata       = cpu_rdata_q;

  // RAM read is launched in the accept cycle so data arrives in LOOKUP.
  assign ram.ram_rd_en   = accept;
  assign ram.ram_rd_addr = accept ? addr_index(cpu.cpu_addr) : '0;

  assign ram.ram_wr_en   = refill_we;
  assign ram.ram_wr_addr = refill_we ? idx_q : '0;
  assign ram.ram_wr_data = refill_we ? mem.mem_rdata : '0;
  assign ram.tag_wr_data = refill_we ? tag_q : '0;

  assign mem.mem_req_valid = mem_req_valid_q;
  assign mem.mem_addr      = mem_addr_q;

endmodule
